// File: rtl/regfile_write_port_if.sv
// Write-request bus into the register-file write engine: valid/ready handshake
// carrying a destination register address and the value to store.
interface regfile_write_port_if #(
  parameter int AW    = 5,
  parameter int WIDTH = 64
);
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Register-file write engine: buffers write requests in an in-order FIFO, issues them
// as a registered one-hot write enable plus data, and flags pending-write hazards.
module regfile_write_port #(
  parameter int WIDTH    = 64,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_write_port_if.slave          wr,
  input  logic                         bank_stall,
  output logic [NREG-1:0]              we,
  output logic [WIDTH-1:0]             wdata,
  input  logic [AW-1:0]                rd_addr,
  output logic                         pend_hit,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    addr_mem_r [DEPTH];
  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0] occ_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [NREG-1:0]  we_r;
  logic [WIDTH-1:0] wdata_r;

  logic ready_s;
  logic push_s;
  logic pop_s;
  logic hit_s;

  // Requests to the zero register or beyond the bank are consumed without being stored.
  function automatic logic addr_writable(input logic [AW-1:0] a);
    return (int'(a) != ZERO_REG) && (int'(a) < NREG);
  endfunction

  // Explicit wrap keeps non-power-of-2 depths seamless.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH - 1)) begin
      n = '0;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Handshake and FIFO push/pop decisions; ready looks only at the stored occupancy.
  always_comb begin
    ready_s = (count_r != CW'(DEPTH));
    push_s  = wr.wr_valid && ready_s && addr_writable(wr.wr_addr);
    pop_s   = (count_r != CW'(0)) && !bank_stall;
  end

  // Hazard lookup over buffered entries and the write being committed this cycle.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (occ_r[i] & (addr_mem_r[i] == rd_addr));
    end
    for (int j = 0; j < NREG; j++) begin
      hit_s = hit_s | (we_r[j] & (int'(rd_addr) == j));
    end
    pend_hit = hit_s & (int'(rd_addr) != ZERO_REG);
  end

  // FIFO storage, pointers, occupancy and the registered write-enable/data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      occ_r   <= '0;
      we_r    <= '0;
      wdata_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= '0;
        data_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        addr_mem_r[tail_r] <= wr.wr_addr;
        data_mem_r[tail_r] <= wr.wr_data;
        occ_r[tail_r]      <= 1'b1;
        tail_r             <= ptr_next(tail_r);
      end else begin
        tail_r <= tail_r;
      end
      if (pop_s) begin
        occ_r[head_r] <= 1'b0;
        head_r        <= ptr_next(head_r);
        we_r          <= {{(NREG-1){1'b0}}, 1'b1} << addr_mem_r[head_r];
        wdata_r       <= data_mem_r[head_r];
      end else begin
        we_r    <= '0;
        wdata_r <= wdata_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign wr.wr_ready = ready_s;
  assign we          = we_r;
  assign wdata       = wdata_r;
  assign count       = count_r;
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: a queue-based model is compared against the
// DUT at every falling edge, with literal expectations pinning the key scenarios.
module tb_regfile_write_port;
  localparam int WIDTH = 64;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int ZREG  = 31;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             bank_stall = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [NREG-1:0]  we;
  logic [WIDTH-1:0] wdata;
  logic             pend_hit;
  logic [1:0]       count;

  regfile_write_port_if #(.AW(AW), .WIDTH(WIDTH)) wif ();

  regfile_write_port #(
    .WIDTH(WIDTH), .NREG(NREG), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZREG)
  ) dut (
    .clk(clk), .reset(reset), .wr(wif), .bank_stall(bank_stall),
    .we(we), .wdata(wdata), .rd_addr(rd_addr), .pend_hit(pend_hit), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: queue of buffered writes, the write being committed, last wdata.
  logic [AW-1:0]    qa [$];
  logic [WIDTH-1:0] qd [$];
  int               m_we_addr = -1;
  logic [WIDTH-1:0] m_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qd.delete();
    m_we_addr = -1;
    m_wdata   = '0;
  endtask

  task automatic check_model();
    logic [NREG-1:0] exp_we;
    logic            exp_hit;
    exp_we  = (m_we_addr >= 0) ? (32'd1 << m_we_addr) : 32'd0;
    exp_hit = (m_we_addr == int'(rd_addr));
    foreach (qa[k]) if (qa[k] == rd_addr) exp_hit = 1'b1;
    if (int'(rd_addr) == ZREG) exp_hit = 1'b0;
    chk("we", 64'(we), 64'(exp_we));
    chk("wdata", wdata, m_wdata);
    chk("count", 64'(count), 64'(qa.size()));
    chk("wr_ready", 64'(wif.wr_ready), 64'(qa.size() < DEPTH));
    chk("pend_hit", 64'(pend_hit), 64'(exp_hit));
  endtask

  // Advance the model across one rising edge from the inputs now applied, then compare.
  task automatic tick();
    bit do_pop;
    bit do_acc;
    if (!reset) begin
      model_reset();
    end else begin
      do_pop = (qa.size() > 0) && !bank_stall;
      do_acc = wif.wr_valid && (qa.size() < DEPTH);
      if (do_pop) begin
        m_we_addr = int'(qa.pop_front());
        m_wdata   = qd.pop_front();
      end else begin
        m_we_addr = -1;
      end
      if (do_acc && int'(wif.wr_addr) != ZREG && int'(wif.wr_addr) < NREG) begin
        qa.push_back(wif.wr_addr);
        qd.push_back(wif.wr_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wif.wr_valid = v;
    wif.wr_addr  = a;
    wif.wr_data  = d;
  endtask

  initial begin
    drive(1'b0, '0, '0);
    repeat (2) tick();
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_ready", 64'(wif.wr_ready), 64'h1);
    reset = 1'b1;
    tick();

    // Single write with two-edge latency.
    drive(1'b1, 5'd5, 64'hDEAD_BEEF);
    tick();
    drive(1'b0, '0, '0);
    tick();
    chk("single_we", 64'(we), 64'h20);
    chk("single_wdata", wdata, 64'hDEAD_BEEF);
    tick();
    chk("single_we_off", 64'(we), 64'h0);

    // Fill under stall; a third request is held until space frees up.
    bank_stall = 1'b1;
    drive(1'b1, 5'd3, 64'd1);
    tick();
    drive(1'b1, 5'd4, 64'd2);
    tick();
    chk("full_count", 64'(count), 64'd2);
    chk("full_ready", 64'(wif.wr_ready), 64'h0);
    drive(1'b1, 5'd6, 64'd3);
    repeat (2) tick();
    chk("held_count", 64'(count), 64'd2);
    bank_stall = 1'b0;
    tick();
    chk("drain_we0", 64'(we), 64'h8);
    tick();
    chk("drain_we1", 64'(we), 64'h10);
    drive(1'b0, '0, '0);
    tick();
    chk("held_we", 64'(we), 64'h40);
    chk("held_wdata", wdata, 64'd3);
    tick();

    // Zero register: handshake completes, nothing is stored or issued.
    drive(1'b1, 5'd31, 64'hFFFF);
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero_we", 64'(we), 64'h0);
      chk("zero_count", 64'(count), 64'h0);
    end

    // Hazard lookup while a write to r7 is stalled, then through its commit cycle.
    bank_stall = 1'b1;
    drive(1'b1, 5'd7, 64'h77);
    tick();
    drive(1'b0, '0, '0);
    rd_addr = 5'd7;
    #1 chk("haz_hit7", 64'(pend_hit), 64'h1);
    rd_addr = 5'd8;
    #1 chk("haz_miss8", 64'(pend_hit), 64'h0);
    rd_addr = 5'd31;
    #1 chk("haz_zero", 64'(pend_hit), 64'h0);
    rd_addr = 5'd7;
    bank_stall = 1'b0;
    tick();
    chk("haz_commit_we", 64'(we), 64'h80);
    chk("haz_commit_hit", 64'(pend_hit), 64'h1);
    tick();
    chk("haz_clear", 64'(pend_hit), 64'h0);

    // Back-to-back pushes with simultaneous pops keep occupancy at one.
    drive(1'b1, 5'd0, 64'h1000);
    tick();
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, AW'(i), 64'h1000 + 64'(i));
      rd_addr = AW'(i);
      tick();
      chk("walk_count", 64'(count), 64'd1);
      chk("walk_we", 64'(we), 64'h1 << (i - 1));
      chk("walk_wdata", wdata, 64'h1000 + 64'(i - 1));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("walk_last", 64'(we), 64'h1 << 19);
    tick();

    // Asynchronous reset between edges with two entries queued.
    bank_stall = 1'b1;
    drive(1'b1, 5'd9, 64'h9);
    tick();
    drive(1'b1, 5'd10, 64'hA);
    tick();
    drive(1'b0, '0, '0);
    #2 reset = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_ready", 64'(wif.wr_ready), 64'h1);
    model_reset();
    tick();
    reset = 1'b1;
    bank_stall = 1'b0;
    tick();
    drive(1'b1, 5'd1, 64'h11);
    tick();
    drive(1'b0, '0, '0);
    tick();
    chk("post_rst_we", 64'(we), 64'h2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
